// File: rtl/keypad_scan_events_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_scan_events_pkg
//  Purpose  : Shared types and helpers for the keypad scanner. These include
//             the key index, the event record and the lowest-set-bit priority
//             pick.
//  Revision : 1.0  initial release
// ============================================================================
package keypad_scan_events_pkg;

   // Largest key matrix the priority helper covers (ROWS*COLS <= 64).
   localparam int KP_MAX_KEYS = 64;
   localparam int KP_CODE_W   = 6;

   typedef struct packed {
      logic [KP_CODE_W-1:0] code;
      logic                 press;
   } key_event_t;

   typedef enum logic [0:0] {
      ST_SCAN  = 1'b0,
      ST_PAUSE = 1'b1
   } scan_state_t;

   // Flat key index of matrix position (r,c).
   function automatic int unsigned idx(input int unsigned r, input int unsigned c,
                                       input int unsigned cols);
      return r * cols + c;
   endfunction

   // Index of the lowest set bit, 0 when the vector is empty.
   function automatic logic [KP_CODE_W-1:0] lowest_set(input logic [KP_MAX_KEYS-1:0] v);
      logic [KP_CODE_W-1:0] res;
      logic                 found;
      res   = '0;
      found = 1'b0;
      for (int i = 0; i < KP_MAX_KEYS; i++) begin
         if (v[i] && !found) begin
            res   = KP_CODE_W'(i);
            found = 1'b1;
         end
      end
      return res;
   endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_scan_events_if.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_scan_events_if
//  Purpose  : Valid/ready key-event channel from the scanner to its consumer.
//  Revision : 1.0  initial release
// ============================================================================
interface keypad_scan_events_if #(
   parameter int KEY_W = 4
);
   logic             key_valid;
   logic [KEY_W-1:0] key_code;
   logic             key_press;
   logic             key_ready;

   modport master (output key_valid, output key_code, output key_press, input  key_ready);
   modport slave  (input  key_valid, input  key_code, input  key_press, output key_ready);
endinterface
`default_nettype wire

// File: rtl/keypad_scan_events_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_scan_events_debounce
//  Purpose  : Frame-level debounce. A raw frame becomes the key map once it
//             has been seen DEBOUNCE_N times in a row.
//  Revision : 1.0  initial release
// ============================================================================
module keypad_scan_events_debounce #(
   parameter int NKEYS      = 16,
   parameter int DEBOUNCE_N = 3
) (
   input  wire logic             clk,
   input  wire logic             rst_n,
   input  wire logic             i_frame_end,
   input  wire logic [NKEYS-1:0] i_raw,
   output logic      [NKEYS-1:0] o_key_state
);
   localparam int              CNT_W     = (DEBOUNCE_N > 1) ? $clog2(DEBOUNCE_N) : 1;
   localparam logic [CNT_W-1:0] c_cnt_cap = CNT_W'(DEBOUNCE_N - 1);

   logic [NKEYS-1:0] r_prev_raw;
   logic [NKEYS-1:0] r_key_state;
   logic [CNT_W-1:0] r_stable_cnt;
   logic [CNT_W-1:0] w_cnt_next;

   // Repeat count after this frame: saturating on a match, cleared on a change.
   always_comb begin
      w_cnt_next = '0;
      if (i_raw == r_prev_raw) begin
         w_cnt_next = (r_stable_cnt == c_cnt_cap) ? r_stable_cnt : r_stable_cnt + 1'b1;
      end
   end

   // Debounce history and accepted key map, advanced once per frame.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_prev_raw   <= '0;
         r_stable_cnt <= '0;
         r_key_state  <= '0;
      end else if (i_frame_end) begin
         r_stable_cnt <= w_cnt_next;
         r_prev_raw   <= i_raw;
         if (w_cnt_next == c_cnt_cap) begin
            r_key_state <= i_raw;
         end
      end
   end

   assign o_key_state = r_key_state;
endmodule
`default_nettype wire

// File: rtl/keypad_scan_events.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_scan_events
//  Purpose  : Matrix keypad scanner. It drives one row low per slot, samples
//             the columns mid-slot and debounces whole frames. It reports
//             key changes as press/release events.
//  Revision : 1.0  initial release
// ============================================================================
module keypad_scan_events
   import keypad_scan_events_pkg::*;
#(
   parameter int ROWS       = 4,
   parameter int COLS       = 4,
   parameter int SCAN_TICKS = 49999,
   parameter int SAMPLE_AT  = 24999,
   parameter int DEBOUNCE_N = 3
) (
   input  wire logic                 sys_clk,
   input  wire logic                 sys_rst,
   input  wire logic                 scan_en,
   input  wire logic [COLS-1:0]      column,
   output wire       [ROWS-1:0]      row,
   output logic      [ROWS*COLS-1:0] key_state,
   output logic                      frame_tick,
   keypad_scan_events_if.master      evt
);
   localparam int NK    = ROWS * COLS;
   localparam int KEY_W = (NK > 1) ? $clog2(NK) : 1;
   localparam int SW    = (SCAN_TICKS > 0) ? $clog2(SCAN_TICKS + 1) : 1;
   localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;

   localparam logic [SW-1:0] c_scan_ticks = SW'(SCAN_TICKS);
   localparam logic [SW-1:0] c_sample_at  = SW'(SAMPLE_AT);
   localparam logic [RW-1:0] c_last_row   = RW'(ROWS - 1);

   scan_state_t        r_state;
   logic [SW-1:0]      r_slot;
   logic [RW-1:0]      r_row_idx;
   logic [ROWS-1:0]    r_row_oe;
   logic [NK-1:0]      r_raw;
   logic               r_frame_tick;
   logic               w_frame_end;
   int unsigned        w_row_base;

   logic               r_valid;
   logic [KEY_W-1:0]   r_code;
   logic               r_press;
   logic [NK-1:0]      r_reported;
   logic [NK-1:0]      w_pending;
   logic [NK-1:0]      w_xfer_mask;
   logic [NK-1:0]      w_cand;
   logic               w_xfer;
   logic               w_load;
   logic               w_found;
   key_event_t         w_next;
   logic [KP_CODE_W-1:0] w_unused_code;

   assign w_frame_end = (r_state == ST_SCAN) && (r_slot == c_scan_ticks) &&
                        (r_row_idx == c_last_row);
   assign w_row_base  = idx(32'(r_row_idx), 0, COLS);

   // Scan sequencer: slot counter, row drive, column sampling and pause.
   always_ff @(posedge sys_clk) begin
      if (!sys_rst) begin
         r_state      <= ST_SCAN;
         r_slot       <= '0;
         r_row_idx    <= '0;
         r_row_oe     <= '0;
         r_raw        <= '0;
         r_frame_tick <= 1'b0;
      end else begin
         r_frame_tick <= w_frame_end;
         case (r_state)
            ST_SCAN: begin
               if (r_slot == '0) begin
                  r_row_oe <= ROWS'(1) << r_row_idx;
               end
               if (r_slot == c_sample_at) begin
                  r_raw[w_row_base +: COLS] <= ~column;
               end
               if (r_slot == c_scan_ticks) begin
                  r_slot <= '0;
                  if (r_row_idx == c_last_row) begin
                     r_row_idx <= '0;
                     // Pausing only at a frame boundary keeps frames whole.
                     if (!scan_en) begin
                        r_state  <= ST_PAUSE;
                        r_row_oe <= '0;
                     end
                  end else begin
                     r_row_idx <= r_row_idx + 1'b1;
                  end
               end else begin
                  r_slot <= r_slot + 1'b1;
               end
            end
            ST_PAUSE: begin
               // Resuming performs the slot-0 step at once, so row 0 drives immediately.
               if (scan_en) begin
                  r_state  <= ST_SCAN;
                  r_row_oe <= ROWS'(1);
                  r_slot   <= SW'(1);
               end
            end
            default: r_state <= ST_SCAN;
         endcase
      end
   end

   for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
      assign row[gi] = r_row_oe[gi] ? 1'b0 : 1'bz;
   end

   keypad_scan_events_debounce #(
      .NKEYS      (NK),
      .DEBOUNCE_N (DEBOUNCE_N)
   ) u_debounce (
      .clk         (sys_clk),
      .rst_n       (sys_rst),
      .i_frame_end (w_frame_end),
      .i_raw       (r_raw),
      .o_key_state (key_state)
   );

   assign frame_tick = r_frame_tick;

   // Next event candidate: lowest pending key, ignoring the one leaving this cycle.
   always_comb begin
      w_xfer      = r_valid && evt.key_ready;
      w_load      = !r_valid || w_xfer;
      w_pending   = key_state ^ r_reported;
      w_xfer_mask = '0;
      if (w_xfer) begin
         w_xfer_mask[r_code] = 1'b1;
      end
      w_cand       = w_pending & ~w_xfer_mask;
      w_found      = |w_cand;
      w_next.code  = lowest_set(KP_MAX_KEYS'(w_cand));
      w_next.press = key_state[w_next.code[KEY_W-1:0]];
   end

   assign w_unused_code = w_next.code;

   // Registered event stage; the reported map tracks what the consumer has seen.
   always_ff @(posedge sys_clk) begin
      if (!sys_rst) begin
         r_valid    <= 1'b0;
         r_code     <= '0;
         r_press    <= 1'b0;
         r_reported <= '0;
      end else begin
         if (w_xfer) begin
            r_reported[r_code] <= r_press;
         end
         if (w_load) begin
            r_valid <= w_found;
            r_code  <= w_next.code[KEY_W-1:0];
            r_press <= w_next.press;
         end
      end
   end

   assign evt.key_valid = r_valid;
   assign evt.key_code  = r_code;
   assign evt.key_press = r_press;
endmodule
`default_nettype wire

// File: tb/tb_keypad_scan_events.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_keypad_scan_events
//  Purpose  : Self-checking bench for keypad_scan_events with a key-matrix
//             model driving the columns from the rows.
//  Revision : 1.0  initial release
// ============================================================================
module tb_keypad_scan_events;
   localparam int ROWS  = 4;
   localparam int COLS  = 4;
   localparam int NK    = 16;
   localparam int KEY_W = 4;
   localparam int NT    = 8;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            scan_en;
   logic [COLS-1:0] column;
   wire  [ROWS-1:0] row;
   logic [NK-1:0]   key_state;
   logic            frame_tick;
   logic [NK-1:0]   keys;
   bit              mon_en;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [KEY_W-1:0] code;
      logic             press;
   } ev_t;

   typedef struct {
      logic [NK-1:0] keys;
      int            frames;
      logic [NK-1:0] exp_state;
   } vec_t;

   vec_t tab [NT];
   ev_t  got_q[$];
   ev_t  exp_q[$];

   always #5 clk = ~clk;

   keypad_scan_events_if #(.KEY_W(KEY_W)) evt ();

   keypad_scan_events #(
      .ROWS(ROWS), .COLS(COLS), .SCAN_TICKS(9), .SAMPLE_AT(4), .DEBOUNCE_N(3)
   ) dut (
      .sys_clk    (clk),
      .sys_rst    (rst_n),
      .scan_en    (scan_en),
      .column     (column),
      .row        (row),
      .key_state  (key_state),
      .frame_tick (frame_tick),
      .evt        (evt)
   );

   // Undriven rows read as 1, like the pulled-up board lines.
   for (genvar g = 0; g < ROWS; g++) begin : g_pull
      pullup pu (row[g]);
   end

   // Key matrix: a held key shorts its column low while its row is driven.
   always_comb begin
      column = '1;
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS; c++) begin
            if (row[r] == 1'b0 && keys[r*COLS+c]) column[c] = 1'b0;
         end
      end
   end

   // Record every accepted event.
   always @(negedge clk) begin
      if (mon_en && rst_n && evt.key_valid && evt.key_ready)
         got_q.push_back({evt.key_code, evt.key_press});
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_tick(input string tag);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!frame_tick && n < 200);
      if (!frame_tick) begin
         checks++;
         errors++;
         $display("FAIL %s: no frame_tick within 200 cycles", tag);
      end
   endtask

   task automatic frames(input int n, input string tag);
      for (int i = 0; i < n; i++) wait_tick(tag);
   endtask

   task automatic check_events(input string tag);
      chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         chk($sformatf("%s_ev%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
      got_q.delete();
      exp_q.delete();
   endtask

   function automatic logic [31:0] evw(input logic v, input int code, input logic p);
      return {26'd0, v, 4'(code), p};
   endfunction

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin : main
      logic [NK-1:0] prev;
      logic [NK-1:0] diff;
      int            n;
      int            bad;

      tab[0] = '{16'h0000, 1, 16'h0000};
      tab[1] = '{16'h0010, 2, 16'h0000};   // bounce: only two frames
      tab[2] = '{16'h0000, 3, 16'h0000};
      tab[3] = '{16'h0010, 3, 16'h0010};   // key 4 press
      tab[4] = '{16'h0000, 3, 16'h0000};   // key 4 release
      tab[5] = '{16'h8001, 3, 16'h8001};   // keys 0 and 15
      tab[6] = '{16'h8000, 3, 16'h8000};
      tab[7] = '{16'h0000, 3, 16'h0000};

      rst_n         = 1'b0;
      scan_en       = 1'b1;
      keys          = '0;
      evt.key_ready = 1'b1;
      mon_en        = 1'b0;

      // Reset sanity and scan timing.
      repeat (5) @(negedge clk);
      chk("rst_row", 32'(row), 32'h000F);
      chk("rst_state", 32'(key_state), 32'h0);
      chk("rst_valid", 32'(evt.key_valid), 32'h0);
      chk("rst_tick", 32'(frame_tick), 32'h0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("row0_first", 32'(row), 32'h000E);
      repeat (10) @(negedge clk);
      chk("row1_slot", 32'(row), 32'h000D);
      wait_tick("first_tick");
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!frame_tick && n < 100);
      chk("tick_period", 32'(n), 32'd40);

      // Table-driven frames, ready held high.
      mon_en = 1'b1;
      prev   = '0;
      for (int i = 0; i < NT; i++) begin
         keys = tab[i].keys;
         if (i > 0) begin
            repeat (20) @(negedge clk);
            check_events($sformatf("step%0d", i - 1));
         end
         for (int f = 1; f <= tab[i].frames; f++) begin
            wait_tick($sformatf("step%0d_tick", i));
            if (f == tab[i].frames - 1)
               chk($sformatf("step%0d_early", i), 32'(key_state), 32'(prev));
         end
         chk($sformatf("step%0d_state", i), 32'(key_state), 32'(tab[i].exp_state));
         diff = prev ^ tab[i].exp_state;
         for (int k = 0; k < NK; k++)
            if (diff[k]) exp_q.push_back({4'(k), tab[i].exp_state[k]});
         prev = tab[i].exp_state;
      end
      repeat (20) @(negedge clk);
      check_events("final");
      mon_en = 1'b0;

      // Two keys under backpressure.
      wait_tick("bp_align");
      evt.key_ready = 1'b0;
      keys = 16'h0204;
      frames(3, "bp");
      chk("bp_state", 32'(key_state), 32'h0204);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk($sformatf("bp_hold%0d", i), {26'd0, evt.key_valid, evt.key_code, evt.key_press},
             evw(1'b1, 2, 1'b1));
      end
      evt.key_ready = 1'b1;
      @(negedge clk);
      chk("bp_second", {26'd0, evt.key_valid, evt.key_code, evt.key_press}, evw(1'b1, 9, 1'b1));
      @(negedge clk);
      chk("bp_drain", 32'(evt.key_valid), 32'h0);
      wait_tick("bp_clr_align");
      keys = '0;
      frames(3, "bp_clr");
      chk("bp_clr_state", 32'(key_state), 32'h0);
      repeat (20) @(negedge clk);

      // Press and release of key 5 collapse under a stalled event for key 3.
      wait_tick("ns_align");
      evt.key_ready = 1'b0;
      keys = 16'h0008;
      frames(3, "ns_k3");
      chk("ns_k3_state", 32'(key_state), 32'h0008);
      @(negedge clk);
      chk("ns_k3_ev", {26'd0, evt.key_valid, evt.key_code, evt.key_press}, evw(1'b1, 3, 1'b1));
      wait_tick("ns_align2");
      keys = 16'h0028;
      frames(3, "ns_k5p");
      chk("ns_k5p_state", 32'(key_state), 32'h0028);
      chk("ns_k5p_held", {26'd0, evt.key_valid, evt.key_code, evt.key_press}, evw(1'b1, 3, 1'b1));
      keys = 16'h0008;
      frames(3, "ns_k5r");
      chk("ns_k5r_state", 32'(key_state), 32'h0008);
      @(negedge clk);
      chk("ns_k5r_held", {26'd0, evt.key_valid, evt.key_code, evt.key_press}, evw(1'b1, 3, 1'b1));
      evt.key_ready = 1'b1;
      bad = 0;
      repeat (6) begin
         @(negedge clk);
         if (evt.key_valid !== 1'b0) bad++;
      end
      chk("ns_no_k5", 32'(bad), 32'h0);
      wait_tick("ns_clr_align");
      keys = '0;
      frames(3, "ns_clr");
      chk("ns_clr_state", 32'(key_state), 32'h0);
      @(negedge clk);
      chk("ns_k3_rel", {26'd0, evt.key_valid, evt.key_code, evt.key_press}, evw(1'b1, 3, 1'b0));
      @(negedge clk);
      chk("ns_idle", 32'(evt.key_valid), 32'h0);

      // Pause at a frame boundary and resume.
      scan_en = 1'b0;
      wait_tick("pause");
      chk("pause_row", 32'(row), 32'h000F);
      bad = 0;
      repeat (100) begin
         @(negedge clk);
         if (frame_tick !== 1'b0 || row !== 4'hF) bad++;
      end
      chk("pause_quiet", 32'(bad), 32'h0);
      scan_en = 1'b1;
      @(negedge clk);
      chk("resume_row", 32'(row), 32'h000E);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!frame_tick && n < 100);
      chk("resume_tick", 32'(n), 32'd39);

      // Reset during a stalled event.
      evt.key_ready = 1'b0;
      keys = 16'h0040;
      frames(3, "rst_k6");
      chk("rst_k6_state", 32'(key_state), 32'h0040);
      @(negedge clk);
      chk("rst_k6_ev", {26'd0, evt.key_valid, evt.key_code, evt.key_press}, evw(1'b1, 6, 1'b1));
      rst_n = 1'b0;
      @(negedge clk);
      chk("rst_mid_valid", 32'(evt.key_valid), 32'h0);
      chk("rst_mid_state", 32'(key_state), 32'h0);
      chk("rst_mid_row", 32'(row), 32'h000F);
      rst_n = 1'b1;
      keys  = '0;
      repeat (5) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
